cvp_vmem_engine: RTL and testbench

Parametrised multi-cycle vector memory engine for the CVP vector core. It moves up to LANES elements of EW bits between a single-port word memory and the vector register datapath. It supports a programmable element count and address stride, and uses a ready/acknowledge memory handshake so memories with wait states work. The core FSM hands it VLD/VST work on a one-cycle start pulse and waits for done.

---
 rtl/cvp_pkg.sv | 24 ++
 rtl/cvp_vmem_addr_gen.sv | 83 ++++++++
 rtl/cvp_vmem_engine.sv | 145 ++++++++++++++
 tb/tb_cvp_vmem_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvp_pkg.sv
// ---------------------------------------------------------------------------
// cvp_pkg
// Shared definitions for the CVP vector core: default vector geometry (used by
// the vector register file, ALU and memory engine), the memory-engine state
// type and the load/store op encoding.
// ---------------------------------------------------------------------------
package cvp_pkg;

  // Default vector geometry shared across the vector datapath.
  localparam int CVP_LANES = 16;
  localparam int CVP_EW    = 16;

  // Memory engine states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } vmem_state_t;

  // Memory engine op encoding.
  localparam logic VMEM_LD = 1'b0;
  localparam logic VMEM_ST = 1'b1;

endpackage

// File: rtl/cvp_vmem_addr_gen.sv
// ---------------------------------------------------------------------------
// cvp_vmem_addr_gen
// Element index counter and address accumulator for the vector memory engine.
// The address is a running sum (addr += stride) so no multiplier is needed;
// arithmetic wraps silently modulo 2^AW.
//
// Build option: CVP_VMEM_STRIDE_EN
//   defined   - the stride input sets the element-to-element increment
//   undefined - the increment is fixed at 1; the stride input is ignored
//
// Ports:
//   Clk1, Reset   clock / synchronous active-high reset
//   load          start accepted: latch base, stride and clamped count
//   advance       current element accepted by memory: step idx and address
//   base_addr     address of element 0
//   stride        address increment between elements
//   count         requested element count (clamped to LANES)
//   lane_idx      current element index, lane-select width
//   addr          current element address
//   last          current element is the final one
//   count_zero    requested count on the input is zero
// ---------------------------------------------------------------------------
module cvp_vmem_addr_gen #(
  parameter int LANES = 16,
  parameter int AW    = 16,
  parameter int CW    = $clog2(LANES + 1),
  parameter int IW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  input  logic [CW-1:0] count,
  output logic [IW-1:0] lane_idx,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          count_zero
);

  logic [CW-1:0] idx_reg;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] addr_reg;
  logic [AW-1:0] stride_reg;
  logic [CW-1:0] count_clamped;
  logic [AW-1:0] eff_stride;

  assign count_clamped = (count > CW'(LANES)) ? CW'(LANES) : count;

`ifdef CVP_VMEM_STRIDE_EN
  assign eff_stride = stride;
`else
  // Legacy unit-stride build: the port stays for interface compatibility.
  logic stride_unused;
  assign stride_unused = ^stride;
  assign eff_stride    = AW'(1);
`endif

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      idx_reg    <= '0;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      stride_reg <= '0;
    end else if (load) begin
      idx_reg    <= '0;
      cnt_reg    <= count_clamped;
      addr_reg   <= base_addr;
      stride_reg <= eff_stride;
    end else if (advance) begin
      idx_reg    <= idx_reg + CW'(1);
      addr_reg   <= addr_reg + stride_reg;
    end
  end

  // Only meaningful while a transfer is in flight (cnt_reg >= 1 there).
  assign last       = (idx_reg == cnt_reg - CW'(1));
  assign count_zero = (count == '0);
  assign lane_idx   = idx_reg[IW-1:0];
  assign addr       = addr_reg;

endmodule

// File: rtl/cvp_vmem_engine.sv
// ---------------------------------------------------------------------------
// cvp_vmem_engine
// Multi-cycle vector load/store engine. Moves up to LANES elements of EW bits
// between a single-port word memory (ready/ack handshake, wait states allowed)
// and the vector register datapath. One element per acknowledged cycle.
//
// Build option: CVP_VMEM_STRIDE_EN (see cvp_vmem_addr_gen) enables the
// programmable stride; without it the engine is unit-stride.
//
// Ports:
//   Clk1, Reset   clock / synchronous active-high reset
//   start         request pulse, sampled only in IDLE
//   op            VMEM_LD (0) or VMEM_ST (1)
//   base_addr     address of element 0
//   stride        address increment between elements
//   count         element count (clamped to LANES)
//   st_data       store source, lane i at [i*EW +: EW], latched at start
//   busy          high whenever not IDLE
//   done          one-cycle completion pulse
//   ld_data       registered load result, unread lanes are 0
//   mem_addr      memory address
//   mem_rd        read request
//   mem_wr        write request
//   mem_wdata     write data
//   mem_rdata     read data, valid while mem_ack is high
//   mem_ack       memory accepts the current request
// ---------------------------------------------------------------------------
module cvp_vmem_engine
  import cvp_pkg::*;
#(
  parameter int LANES = CVP_LANES,
  parameter int EW    = CVP_EW,
  parameter int AW    = 16,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic                Clk1,
  input  logic                Reset,
  input  logic                start,
  input  logic                op,
  input  logic [AW-1:0]       base_addr,
  input  logic [AW-1:0]       stride,
  input  logic [CW-1:0]       count,
  input  logic [LANES*EW-1:0] st_data,
  output logic                busy,
  output logic                done,
  output logic [LANES*EW-1:0] ld_data,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [EW-1:0]       mem_wdata,
  input  logic [EW-1:0]       mem_rdata,
  input  logic                mem_ack
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  vmem_state_t   state_reg;
  vmem_state_t   state_next;
  logic          op_reg;
  logic          start_accept;
  logic          ack_fire;
  logic [IW-1:0] lane_idx;
  logic          last;
  logic          count_zero;

  logic [EW-1:0] st_lane_reg [LANES];
  logic [EW-1:0] ld_lane_reg [LANES];

  assign start_accept = (state_reg == IDLE) && start;
  // mem_ack is only meaningful while a request is being driven.
  assign ack_fire     = (state_reg == XFER) && mem_ack;

  cvp_vmem_addr_gen #(
    .LANES(LANES),
    .AW   (AW),
    .CW   (CW),
    .IW   (IW)
  ) u_addr_gen (
    .Clk1      (Clk1),
    .Reset     (Reset),
    .load      (start_accept),
    .advance   (ack_fire),
    .base_addr (base_addr),
    .stride    (stride),
    .count     (count),
    .lane_idx  (lane_idx),
    .addr      (mem_addr),
    .last      (last),
    .count_zero(count_zero)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = count_zero ? DONE : XFER;
      XFER:    if (mem_ack && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_reg <= IDLE;
      op_reg    <= VMEM_LD;
    end else begin
      state_reg <= state_next;
      if (start_accept) op_reg <= op;
    end
  end

  // Per-lane store latch and load result registers.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge Clk1) begin
        if (Reset) begin
          st_lane_reg[gi] <= '0;
        end else if (start_accept) begin
          st_lane_reg[gi] <= st_data[gi*EW +: EW];
        end
      end

      // Cleared when a load is accepted so lanes beyond count read as 0;
      // stores leave the previous load result untouched.
      always_ff @(posedge Clk1) begin
        if (Reset) begin
          ld_lane_reg[gi] <= '0;
        end else if (start_accept && (op == VMEM_LD)) begin
          ld_lane_reg[gi] <= '0;
        end else if (ack_fire && (op_reg == VMEM_LD) && (lane_idx == IW'(gi))) begin
          ld_lane_reg[gi] <= mem_rdata;
        end
      end

      assign ld_data[gi*EW +: EW] = ld_lane_reg[gi];
    end
  endgenerate

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign mem_rd    = (state_reg == XFER) && (op_reg == VMEM_LD);
  assign mem_wr    = (state_reg == XFER) && (op_reg == VMEM_ST);
  assign mem_wdata = st_lane_reg[lane_idx];

endmodule

// File: tb/tb_cvp_vmem_engine.sv
// ---------------------------------------------------------------------------
// tb_cvp_vmem_engine
// Self-checking bench for cvp_vmem_engine: directed table, hand-written
// corner sequences and randomized operations against a behavioural model
// with an array-backed memory.
// ---------------------------------------------------------------------------
module tb_cvp_vmem_engine;

  localparam int LANES = 16;
  localparam int EW    = 16;
  localparam int AW    = 16;
  localparam int CW    = 5;
`ifdef CVP_VMEM_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic                Clk1 = 1'b0;
  logic                Reset = 1'b1;
  logic                start = 1'b0;
  logic                op = 1'b0;
  logic [AW-1:0]       base_addr = '0;
  logic [AW-1:0]       stride = '0;
  logic [CW-1:0]       count = '0;
  logic [LANES*EW-1:0] st_data = '0;
  logic                busy, done, mem_rd, mem_wr;
  logic [LANES*EW-1:0] ld_data;
  logic [AW-1:0]       mem_addr;
  logic [EW-1:0]       mem_wdata, mem_rdata;
  logic                mem_ack = 1'b0;

  logic [EW-1:0] mem [65536];

  always #5 Clk1 = ~Clk1;

  assign mem_rdata = mem_ack ? mem[mem_addr] : 16'hDEAD;

  cvp_vmem_engine #(.LANES(LANES), .EW(EW), .AW(AW), .CW(CW)) dut (
    .Clk1(Clk1), .Reset(Reset), .start(start), .op(op),
    .base_addr(base_addr), .stride(stride), .count(count), .st_data(st_data),
    .busy(busy), .done(done), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int checks = 0;
  int errors = 0;

  bit                  ack_pat [256];
  logic [LANES*EW-1:0] exp_ld = '0;

  // Observations of the last run.
  logic [AW-1:0]       obs_addr [$];
  bit                  obs_wr [$];
  logic [EW-1:0]       obs_wdata [$];
  int                  obs_done;
  logic [LANES*EW-1:0] obs_ld;
  bit                  obs_bad_req;
  bit                  obs_busy_bad;
  bit                  obs_idle_ok;

  typedef struct {
    bit            o;
    logic [AW-1:0] b;
    logic [AW-1:0] s;
    logic [CW-1:0] n;
    int            mode;
    int            exp_done;
    int            exp_n;
    logic [AW-1:0] last_en;
    logic [AW-1:0] last_un;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // 0: always ack, 1: ack on even cycles, 2: random 50%, 3: random 75%
  task automatic set_ack(input int mode);
    for (int c = 0; c < 256; c++) begin
      case (mode)
        0:       ack_pat[c] = 1'b1;
        1:       ack_pat[c] = (c % 2 == 0);
        2:       ack_pat[c] = $urandom_range(0, 1) == 1;
        default: ack_pat[c] = ($urandom % 4) != 0;
      endcase
    end
  endtask

  function automatic logic [LANES*EW-1:0] rand_vec();
    logic [LANES*EW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Issue one operation; poke = cycle in which to pulse start again (0 = never).
  task automatic run_op(input bit o, input logic [AW-1:0] b, input logic [AW-1:0] s,
                        input logic [CW-1:0] n, input logic [LANES*EW-1:0] sd, input int poke);
    obs_addr.delete(); obs_wr.delete(); obs_wdata.delete();
    obs_done = -1; obs_ld = '0; obs_bad_req = 0; obs_busy_bad = 0;
    @(negedge Clk1);
    op = o; base_addr = b; stride = s; count = n; st_data = sd; start = 1'b1; mem_ack = 1'b1;
    @(negedge Clk1);
    // Scramble inputs: the engine must work from its latched copies.
    start = 1'b0; st_data = rand_vec(); base_addr = AW'($urandom); stride = AW'($urandom);
    count = 5'd1; op = ~o;
    for (int c = 1; c < 256; c++) begin
      mem_ack = ack_pat[c];
      start   = (c == poke);
      if (!busy) obs_busy_bad = 1;
      if (mem_rd && mem_wr) obs_bad_req = 1;
      if (done) begin
        obs_done = c;
        obs_ld   = ld_data;
        if (mem_rd || mem_wr) obs_bad_req = 1;
        break;
      end
      if ((mem_rd || mem_wr) && mem_ack) begin
        obs_addr.push_back(mem_addr);
        obs_wr.push_back(mem_wr);
        obs_wdata.push_back(mem_wdata);
      end
      @(negedge Clk1);
    end
    @(negedge Clk1);
    start = 1'b0; mem_ack = 1'b0;
    obs_idle_ok = !busy && !done && !mem_rd && !mem_wr;
  endtask

  // Run one operation and compare against the reference behaviour.
  task automatic do_test(input string nm, input bit o, input logic [AW-1:0] b,
                         input logic [AW-1:0] s, input logic [CW-1:0] n,
                         input int mode, input int poke);
    logic [LANES*EW-1:0] sd;
    logic [AW-1:0]       ea [$];
    int nn, c;
    sd = rand_vec();
    set_ack(mode);
    run_op(o, b, s, n, sd, poke);
    nn = (int'(n) > LANES) ? LANES : int'(n);
    for (int i = 0; i < nn; i++) ea.push_back(b + AW'(i) * (STRIDE_EN ? s : AW'(1)));
    c = 1;
    for (int i = 0; i < nn; i++) begin
      while (!ack_pat[c]) c++;
      c++;
    end
    chk({nm, " done_cycle"}, obs_done, c);
    chk({nm, " xfer_count"}, obs_addr.size(), nn);
    chk({nm, " busy_during_op"}, obs_busy_bad, 0);
    chk({nm, " req_exclusive"}, obs_bad_req, 0);
    chk({nm, " back_to_idle"}, obs_idle_ok, 1);
    for (int i = 0; i < nn && i < obs_addr.size(); i++) begin
      chk($sformatf("%s addr[%0d]", nm, i), obs_addr[i], ea[i]);
      chk($sformatf("%s kind[%0d]", nm, i), obs_wr[i], o);
      if (o) chk($sformatf("%s wdata[%0d]", nm, i), obs_wdata[i], sd[i*EW +: EW]);
    end
    if (!o) begin
      exp_ld = '0;
      for (int i = 0; i < nn; i++) exp_ld[i*EW +: EW] = mem[ea[i]];
    end
    chk({nm, " ld_data"}, obs_ld, exp_ld);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = EW'($urandom);
    mem[16'h0100] = 16'h3C00; mem[16'h0101] = 16'h4000;
    mem[16'h0102] = 16'h4200; mem[16'h0103] = 16'h4400;

    //               op    base      stride  cnt  mode done n   last(stride) last(unit)
    vecs[0] = '{1'b0, 16'h0100, 16'd1, 5'd4,  0, 5,  4,  16'h0103, 16'h0103};
    vecs[1] = '{1'b1, 16'h0010, 16'd3, 5'd3,  1, 7,  3,  16'h0016, 16'h0012};
    vecs[2] = '{1'b0, 16'hFFFE, 16'd1, 5'd4,  0, 5,  4,  16'h0001, 16'h0001};
    vecs[3] = '{1'b0, 16'h0400, 16'd1, 5'd0,  0, 1,  0,  16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 16'h0200, 16'd2, 5'd20, 0, 17, 16, 16'h021E, 16'h020F};
    vecs[5] = '{1'b0, 16'h0020, 16'd5, 5'd3,  0, 4,  3,  16'h002A, 16'h0022};

    // Reset state
    repeat (3) @(negedge Clk1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mem_rd", mem_rd, 0);
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset ld_data", ld_data, 0);
    Reset = 1'b0;

    // Directed table
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      do_test(nm, vecs[v].o, vecs[v].b, vecs[v].s, vecs[v].n, vecs[v].mode, 0);
      $display("vec%0d op=%0d base=%h count=%0d done_cycle=%0d xfers=%0d", v, vecs[v].o,
               vecs[v].b, vecs[v].n, obs_done, obs_addr.size());
      chk({nm, " tbl_done"}, obs_done, vecs[v].exp_done);
      chk({nm, " tbl_count"}, obs_addr.size(), vecs[v].exp_n);
      if (vecs[v].exp_n > 0 && obs_addr.size() > 0)
        chk({nm, " tbl_last_addr"}, obs_addr[obs_addr.size()-1],
            STRIDE_EN ? vecs[v].last_en : vecs[v].last_un);
    end

    // start while busy: mid-transfer and in the DONE cycle
    do_test("poke_xfer", 1'b0, 16'h0500, 16'd1, 5'd5, 0, 2);
    $display("poke_xfer done_cycle=%0d xfers=%0d", obs_done, obs_addr.size());
    do_test("poke_done", 1'b1, 16'h0600, 16'd2, 5'd3, 0, 4);
    $display("poke_done done_cycle=%0d xfers=%0d", obs_done, obs_addr.size());

    // Reset mid-load after 2 of 8 elements
    begin
      bit saw_done;
      set_ack(0);
      @(negedge Clk1);
      op = 1'b0; base_addr = 16'h0700; stride = 16'd1; count = 5'd8; start = 1'b1; mem_ack = 1'b1;
      @(negedge Clk1);
      start = 1'b0;
      @(negedge Clk1);
      @(negedge Clk1);
      Reset = 1'b1;
      @(negedge Clk1);
      chk("rst_mid busy", busy, 0);
      chk("rst_mid mem_rd", mem_rd, 0);
      chk("rst_mid ld_data", ld_data, 0);
      chk("rst_mid done", done, 0);
      Reset = 1'b0;
      exp_ld = '0;
      saw_done = 0;
      repeat (4) begin
        @(negedge Clk1);
        if (done || busy) saw_done = 1;
      end
      chk("rst_mid no_done", saw_done, 0);
      mem_ack = 1'b0;
      $display("rst_mid busy=%0d ld_zero=%0d", busy, ld_data == '0);
    end

    // Randomized operations
    for (int r = 0; r < 40; r++) begin
      bit            o;
      logic [AW-1:0] b, s;
      logic [CW-1:0] n;
      int            poke;
      o    = $urandom_range(0, 1) == 1;
      b    = AW'($urandom);
      s    = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      n    = CW'($urandom_range(0, 20));
      poke = ($urandom % 4 == 0) ? $urandom_range(1, 6) : 0;
      do_test($sformatf("rnd%0d", r), o, b, s, n, $urandom_range(0, 3), poke);
      $display("rnd%0d op=%0d base=%h stride=%h count=%0d done_cycle=%0d xfers=%0d",
               r, o, b, s, n, obs_done, obs_addr.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
